pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sequences the board PLL from the free-running 24 MHz reference clock domain.
- Holds PLL reset for a minimum time, then waits for lock with a timeout and retries.
- Qualifies lock stability, then releases the system reset request.
- On loss of lock or a software restart, tears down and re-sequences. Sits between the PLL wrapper and the top-level reset distribution.

Parameters:
- HOLD_CYCLES, 24: refclk cycles PLL reset stays asserted per attempt (1 us).
- LOCK_TIMEOUT, 24000: cycles allowed in WAIT_LOCK before retry (1 ms).
- STABLE_CYCLES, 2400: cycles lock must stay continuously high before release (100 us).
- MAX_RETRIES, 3: failed lock attempts before FAULT.
- SYNC_STAGES, 2: flops in the pll_locked synchroniser, minimum 2.

Ports:
- refclk, input, 1: reference clock; sole clock of the block.
- reset_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
- restart_req, input, 1: single-cycle pulse requesting a full re-sequence.
- pll_reset, output, 1: active-high reset driven to the PLL.
- sys_reset_n, output, 1: active-low system reset request; downstream logic synchronises it into the PLL clock domain.
- state_o, output, 3: current FSM state encoding.
- retry_cnt, output, 2: lock attempts that failed since the last RUN or reset.
- fault, output, 1: sticky; retries exhausted.
- lost_lock, output, 1: single-cycle pulse when lock drops while in RUN.

Behaviour:
- Reset values: pll_reset=1, sys_reset_n=0, state=HOLD, retry_cnt=0, fault=0, lost_lock=0, all counters=0.
- pll_locked passes through a SYNC_STAGES flop chain. The FSM sees only the synchronised value lk, so lock has SYNC_STAGES cycles of latency.
- One shared counter, cleared on every state transition.
- HOLD (0):
  - pll_reset=1, sys_reset_n=0.
  - After HOLD_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK (1):
  - pll_reset=0, sys_reset_n=0.
  - lk=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with lk=0: if retry_cnt==MAX_RETRIES-1 -> FAULT; else retry_cnt++ -> HOLD.
- STABLE (2):
  - pll_reset=0, sys_reset_n=0.
  - lk=0 -> HOLD, retry_cnt unchanged; a lock glitch is not counted as a timeout.
  - Counter reaches STABLE_CYCLES-1 with lk still 1 -> RUN.
- RUN (3):
  - sys_reset_n=1, registered and asserted the cycle the state enters RUN. retry_cnt cleared on entry.
  - lk=0 -> lost_lock pulse, then HOLD; sys_reset_n=0 in that same cycle.
- FAULT (4):
  - pll_reset=1, sys_reset_n=0, fault=1.
  - Left only by restart_req or reset_n.
- restart_req in any state: next state HOLD, counter cleared, retry_cnt cleared, fault cleared. It has priority over every other transition in the same cycle.
- Asynchronous reset mid-sequence returns everything to reset values immediately.
- Counter width is ceil(log2(max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))). It must never wrap; terminal compares are equality on N-1.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: PLL_LOCK_FILTER_EN.
- Defined: in RUN, lock loss is declared only after lk is low for 8 consecutive cycles, using a dedicated 3-bit counter that clears whenever lk is high. Shorter dropouts are ignored, with no lost_lock pulse.
- Undefined: a single cycle of lk=0 in RUN triggers lost_lock and HOLD.
- STABLE and WAIT_LOCK behaviour is identical either way.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4;
  - filter length constant LOCK_FILTER_LEN=8;
  - a clog2 helper for the counter width.
- One sub-module, sync_bit: a parameterised SYNC_STAGES flop synchroniser with async active-low reset to 0. It is reused by the top-level reset distribution.

Test Plan:
- Nominal: after reset release, raise pll_locked at cycle 100 and hold it. Expect pll_reset falls at cycle 24; sys_reset_n rises at 100 + SYNC_STAGES + 2400 (±1); retry_cnt=0.
- Timeout and retry: hold pll_locked=0. Expect 3 pll_reset pulses of 24 cycles, each separated by 24000 low cycles. retry_cnt steps 1 and 2, then fault=1 with pll_reset held high.
- Lock loss in RUN: drop pll_locked for 1 cycle. Without the macro: lost_lock pulse, sys_reset_n=0, state=HOLD. With PLL_LOCK_FILTER_EN: no reaction. A 10-cycle drop triggers lost_lock after 8 synchronised low cycles.
- Glitch during STABLE: drop lock at cycle 500 of STABLE. Expect return to HOLD, retry_cnt unchanged, and a full new sequence.
- restart_req: pulse it in FAULT, and separately in RUN on the same cycle lock drops. Expect state HOLD, fault=0, retry_cnt=0, lost_lock still pulses in the RUN case.
- Async reset: assert reset_n low mid-WAIT_LOCK between clock edges. Expect outputs at reset values before the next refclk edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding,
// lock-loss filter length and a width helper for the shared cycle counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int LOCK_FILTER_LEN = 8;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits == 0) bits = 1;
        return bits;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit; async active-low
// reset clears the whole chain to 0.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer in the refclk domain. Define PLL_LOCK_FILTER_EN to
// ignore lock dropouts in RUN shorter than LOCK_FILTER_LEN synchronised cycles.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 24,
    parameter int LOCK_TIMEOUT  = 24000,
    parameter int STABLE_CYCLES = 2400,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt,
    output logic       fault,
    output logic       lost_lock
);

    localparam int CNT_W = clog2(max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             lk;
    logic             lock_lost;
    logic             loss;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(reset_n),
        .d    (pll_locked),
        .q    (lk)
    );

`ifdef PLL_LOCK_FILTER_EN
    // Counts consecutive low lock samples while running; any high sample clears it.
    logic [2:0] filt_q;

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
        end else if (state_q == RUN && !lk) begin
            filt_q <= filt_q + 3'd1;
        end else begin
            filt_q <= '0;
        end
    end

    assign lock_lost = !lk && (filt_q == 3'(LOCK_FILTER_LEN - 1));
`else
    assign lock_lost = !lk;
`endif

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        loss    = 1'b0;

        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = HOLD;
                    end
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = HOLD;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (lock_lost) begin
                    loss    = 1'b1;
                    state_d = HOLD;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // Restart overrides any other transition but still reports a coincident lock loss.
        if (restart_req) begin
            state_d = HOLD;
            retry_d = '0;
        end

        if (restart_req || state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != RUN && state_q != FAULT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            fault       <= 1'b0;
            lost_lock   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset   <= (state_d == HOLD) || (state_d == FAULT);
            sys_reset_n <= (state_d == RUN);
            fault       <= (state_d == FAULT);
            lost_lock   <= loss;
        end
    end

    assign state_o   = state_q;
    assign retry_cnt = retry_q;

endmodule
